// File: rtl/bcd_alu_host.sv
// bcd_alu_host: initiator side of the serial BCD ALU link.
// A parallel command {A5, op, a, b} goes out on tx as a 41-bit frame, MSB first.
// The block then hunts rx for header 8'h96 and captures the 20-bit result behind it.
// Optional build macro BCD_CHECK_EN rejects starts whose operands contain a non-BCD
// nibble and reports the rejection on err.
// Handshake: start is a request sampled only in IDLE. A start seen while busy is
// dropped, not queued. done, timeout and err are single-cycle pulses.
module bcd_alu_host #(
    parameter int TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        tx,
    input  logic        rx,
    output logic        busy,
    output logic        done,
    output logic [19:0] result,
    output logic        timeout,
    output logic        err,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RECV = 2'd3;

    localparam logic [9:0] TMO_LIMIT  = 10'(TIMEOUT);
    localparam logic [7:0] CMD_HEADER = 8'hA5;
    localparam logic [7:0] RES_HEADER = 8'h96;

    logic [1:0]  state_q,   state_d;
    logic [40:0] frame_q,   frame_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  hunt_q,    hunt_d;
    logic [9:0]  tmo_cnt_q, tmo_cnt_d;
    logic [19:0] cap_q,     cap_d;
    logic [19:0] result_q,  result_d;
    logic        tx_q,      tx_d;
    logic        done_q,    done_d;
    logic        timeout_q, timeout_d;
    logic        err_q,     err_d;

    logic        start_reject;
    logic [40:0] frame_new;
    logic [7:0]  hunt_next;
    logic [9:0]  tmo_next;

`ifdef BCD_CHECK_EN
    // A nibble above 9 is not a BCD digit.
    function automatic logic has_bad_digit(input logic [15:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (v[i*4 +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    assign start_reject = has_bad_digit(a) | has_bad_digit(b);
`else
    assign start_reject = 1'b0;
`endif

    assign frame_new = {CMD_HEADER, op, a, b};
    assign hunt_next = {hunt_q[6:0], rx};
    assign tmo_next  = tmo_cnt_q + 10'd1;

    // Next-state logic for the IDLE -> SEND -> WAIT -> RECV sequence.
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        bit_cnt_d = bit_cnt_q;
        hunt_d    = hunt_q;
        tmo_cnt_d = tmo_cnt_q;
        cap_d     = cap_q;
        result_d  = result_q;
        tx_d      = 1'b0;   // tx is only ever non-zero while a frame is being sent
        done_d    = 1'b0;
        timeout_d = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (start_reject) begin
                        err_d = 1'b1;
                    end else begin
                        frame_d   = frame_new;
                        tx_d      = frame_new[40];
                        bit_cnt_d = 6'd40;
                        state_d   = S_SEND;
                    end
                end
            end
            S_SEND: begin
                if (bit_cnt_q == 6'd0) begin
                    hunt_d    = 8'd0;
                    tmo_cnt_d = 10'd0;
                    state_d   = S_WAIT;
                end else begin
                    frame_d   = {frame_q[39:0], 1'b0};
                    tx_d      = frame_q[39];
                    bit_cnt_d = bit_cnt_q - 6'd1;
                end
            end
            S_WAIT: begin
                hunt_d    = hunt_next;
                tmo_cnt_d = tmo_next;
                // A header match wins over expiry on the same edge.
                if (hunt_next == RES_HEADER) begin
                    bit_cnt_d = 6'd19;
                    state_d   = S_RECV;
                end else if (tmo_next == TMO_LIMIT) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                cap_d     = {cap_q[18:0], rx};
                bit_cnt_d = bit_cnt_q - 6'd1;
                if (bit_cnt_q == 6'd0) begin
                    result_d = {cap_q[18:0], rx};
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
        endcase
    end

    // State and output registers; reset forces tx low at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            frame_q   <= '0;
            bit_cnt_q <= '0;
            hunt_q    <= '0;
            tmo_cnt_q <= '0;
            cap_q     <= '0;
            result_q  <= '0;
            tx_q      <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            bit_cnt_q <= bit_cnt_d;
            hunt_q    <= hunt_d;
            tmo_cnt_q <= tmo_cnt_d;
            cap_q     <= cap_d;
            result_q  <= result_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
        end
    end

    assign tx        = tx_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign result    = result_q;
    assign timeout   = timeout_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bcd_alu_host.sv
// Testbench for bcd_alu_host with a behavioural BCD ALU on the far end of the link.
module tb_bcd_alu_host;

    logic        clock;
    logic        reset;
    logic        start;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic        tx;
    logic        rx;
    logic        busy;
    logic        done;
    logic [19:0] result;
    logic        timeout;
    logic        err;
    logic [1:0]  dbg_state;

    int total;
    int bad;
    int ref_lat;

    logic alu_en;
    logic alu_kill;

    bcd_alu_host #(.TIMEOUT(64)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .tx        (tx),
        .rx        (rx),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .timeout   (timeout),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural ALU model
    function automatic int bcd2int(input logic [15:0] v);
        return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [19:0] int2bcd5(input int n);
        logic [19:0] r;
        r[3:0]   = 4'(n % 10);
        r[7:4]   = 4'((n / 10) % 10);
        r[11:8]  = 4'((n / 100) % 10);
        r[15:12] = 4'((n / 1000) % 10);
        r[19:16] = 4'((n / 10000) % 10);
        return r;
    endfunction

    initial begin
        int          m_state;
        int          m_cnt;
        logic [7:0]  m_hunt;
        logic [32:0] m_frame;
        logic [27:0] m_out;
        int          av;
        int          bv;
        int          rv;
        m_state = 0;
        m_cnt   = 0;
        m_hunt  = '0;
        m_frame = '0;
        m_out   = '0;
        rx      = 1'b0;
        forever begin
            @(negedge clock);
            if (alu_kill) begin
                m_state = 0;
                m_hunt  = '0;
                rx      = 1'b0;
            end else begin
                case (m_state)
                    0: begin
                        m_hunt = {m_hunt[6:0], tx};
                        if (alu_en && m_hunt == 8'hA5) begin
                            m_state = 1;
                            m_cnt   = 0;
                        end
                    end
                    1: begin
                        m_frame = {m_frame[31:0], tx};
                        m_cnt++;
                        if (m_cnt == 33) begin
                            av = bcd2int(m_frame[31:16]);
                            bv = bcd2int(m_frame[15:0]);
                            if (m_frame[32])
                                rv = (av - bv + 10000) % 10000;
                            else
                                rv = av + bv;
                            m_out   = {8'h96, int2bcd5(rv)};
                            m_state = 2;
                            m_cnt   = 0;
                        end
                    end
                    2: begin
                        m_cnt++;
                        if (m_cnt == 3) begin
                            m_state = 3;
                            m_cnt   = 0;
                        end
                    end
                    3: begin
                        rx    = m_out[27];
                        m_out = {m_out[26:0], 1'b0};
                        m_cnt++;
                        if (m_cnt == 28) m_state = 4;
                    end
                    default: begin
                        rx      = 1'b0;
                        m_hunt  = '0;
                        m_state = 0;
                    end
                endcase
            end
        end
    end

    // Driver: issue one command at the current negedge and wait for done.
    // Returns at the negedge where done is high (lat = 0 if it never came).
    task automatic run_op(input logic op_v, input logic [15:0] a_v, input logic [15:0] b_v,
                          output logic [40:0] seq, output int lat,
                          output logic [19:0] res, output logic busy_at);
        op    = op_v;
        a     = a_v;
        b     = b_v;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        seq     = '0;
        lat     = 0;
        res     = '0;
        busy_at = 1'b1;
        for (int k = 1; k <= 400 && lat == 0; k++) begin
            @(negedge clock);
            if (k <= 41) seq[41-k] = tx;
            if (done) begin
                lat     = k;
                res     = result;
                busy_at = busy;
            end
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        alu_kill = 1'b1;
        alu_en   = 1'b1;
        start    = 1'b0;
        op       = 1'b0;
        a        = '0;
        b        = '0;
        repeat (3) @(negedge clock);
        total++;
        if ({tx, busy, done, timeout, err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=00000", {tx, busy, done, timeout, err});
        end
        total++;
        if (result !== 20'h0) begin
            bad++;
            $display("FAIL reset_result got=%h exp=00000", result);
        end
        total++;
        if (dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL reset_state got=%0d exp=0", dbg_state);
        end
        reset = 1'b0;
        #1 alu_kill = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_add();
        logic [40:0] seq;
        logic [40:0] exp_seq;
        int          lat;
        logic [19:0] res;
        logic        busy_at;
        exp_seq = {8'hA5, 1'b0, 16'h1234, 16'h0567};
        run_op(1'b0, 16'h1234, 16'h0567, seq, lat, res, busy_at);
        ref_lat = lat;
        total++;
        if (seq !== exp_seq) begin
            bad++;
            $display("FAIL add_frame got=%h exp=%h", seq, exp_seq);
        end
        total++;
        if (lat == 0) begin
            bad++;
            $display("FAIL add_done_wait got=none exp=done within 400 cycles");
        end
        total++;
        if (res !== 20'h01801) begin
            bad++;
            $display("FAIL add_result got=%h exp=01801", res);
        end
        total++;
        if (busy_at !== 1'b0) begin
            bad++;
            $display("FAIL add_busy_at_done got=%b exp=0", busy_at);
        end
        @(negedge clock);
        total++;
        if ({done, tx} !== 2'b00) begin
            bad++;
            $display("FAIL add_done_single got=%b exp=00", {done, tx});
        end
    endtask

    task automatic test_sub();
        logic [40:0] seq;
        int          lat;
        logic [19:0] res;
        logic        busy_at;
        run_op(1'b1, 16'h1234, 16'h0567, seq, lat, res, busy_at);
        total++;
        if (res !== 20'h00667) begin
            bad++;
            $display("FAIL sub_result got=%h exp=00667", res);
        end
        total++;
        if (lat != ref_lat || lat == 0) begin
            bad++;
            $display("FAIL sub_latency got=%0d exp=%0d", lat, ref_lat);
        end
        @(negedge clock);
        run_op(1'b1, 16'h0000, 16'h0001, seq, lat, res, busy_at);
        total++;
        if (res !== 20'h09999) begin
            bad++;
            $display("FAIL sub_wrap_result got=%h exp=09999", res);
        end
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        logic [40:0] seq;
        int          lat;
        logic [19:0] res;
        logic        busy_at;
        run_op(1'b0, 16'h9999, 16'h0001, seq, lat, res, busy_at);
        total++;
        if (res !== 20'h10000) begin
            bad++;
            $display("FAIL carry_result got=%h exp=10000", res);
        end
        // Re-issue during the done cycle itself.
        run_op(1'b0, 16'h9999, 16'h0001, seq, lat, res, busy_at);
        total++;
        if (res !== 20'h10000) begin
            bad++;
            $display("FAIL b2b_result got=%h exp=10000", res);
        end
        total++;
        if (lat != ref_lat || lat == 0) begin
            bad++;
            $display("FAIL b2b_latency got=%0d exp=%0d", lat, ref_lat);
        end
        @(negedge clock);
    endtask

    task automatic test_timeout();
        logic        to_105;
        logic        to_106;
        logic        to_107;
        logic        busy_105;
        logic        busy_107;
        logic [19:0] res_106;
        logic [40:0] seq;
        int          lat;
        logic [19:0] res;
        logic        busy_at;
        alu_en = 1'b0;
        op     = 1'b0;
        a      = 16'h0011;
        b      = 16'h0022;
        start  = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        to_105 = 1'b0; to_106 = 1'b0; to_107 = 1'b0;
        busy_105 = 1'b0; busy_107 = 1'b1; res_106 = '0;
        for (int k = 1; k <= 107; k++) begin
            @(negedge clock);
            if (k == 105) begin to_105 = timeout; busy_105 = busy; end
            if (k == 106) begin to_106 = timeout; res_106 = result; end
            if (k == 107) begin to_107 = timeout; busy_107 = busy; end
        end
        total++;
        if ({to_105, to_106, to_107} !== 3'b010) begin
            bad++;
            $display("FAIL timeout_pulse got=%b exp=010", {to_105, to_106, to_107});
        end
        total++;
        if ({busy_105, busy_107} !== 2'b10) begin
            bad++;
            $display("FAIL timeout_busy got=%b exp=10", {busy_105, busy_107});
        end
        total++;
        if (res_106 !== 20'h10000) begin
            bad++;
            $display("FAIL timeout_result_hold got=%h exp=10000", res_106);
        end
        alu_en = 1'b1;
        run_op(1'b0, 16'h0042, 16'h0058, seq, lat, res, busy_at);
        total++;
        if (res !== 20'h00100) begin
            bad++;
            $display("FAIL after_timeout_result got=%h exp=00100", res);
        end
        @(negedge clock);
    endtask

    task automatic test_reset_mid_frame();
        logic [40:0] seq;
        int          lat;
        logic [19:0] res;
        logic        busy_at;
        op    = 1'b0;
        a     = 16'h1234;
        b     = 16'h0567;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (20) @(negedge clock);
        // 20th sent bit is frame bit 21 = a[5] = 1.
        total++;
        if ({busy, tx} !== 2'b11) begin
            bad++;
            $display("FAIL mid_send_state got=%b exp=11", {busy, tx});
        end
        #1;
        reset    = 1'b1;
        alu_kill = 1'b1;
        #1;
        total++;
        if ({tx, busy, done} !== 3'b000) begin
            bad++;
            $display("FAIL mid_reset_async got=%b exp=000", {tx, busy, done});
        end
        total++;
        if (result !== 20'h0) begin
            bad++;
            $display("FAIL mid_reset_result got=%h exp=00000", result);
        end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1 alu_kill = 1'b0;
        @(negedge clock);
        run_op(1'b0, 16'h0001, 16'h0002, seq, lat, res, busy_at);
        total++;
        if (res !== 20'h00003) begin
            bad++;
            $display("FAIL after_reset_result got=%h exp=00003", res);
        end
        @(negedge clock);
    endtask

    task automatic test_bcd_check();
`ifdef BCD_CHECK_EN
        logic err_first;
        logic busy_first;
        int   tx_ones;
        int   done_cnt;
        int   err_cnt;
        op    = 1'b0;
        a     = 16'h12A4;
        b     = 16'h0001;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        @(negedge clock);
        err_first  = err;
        busy_first = busy;
        tx_ones  = 0;
        done_cnt = 0;
        err_cnt  = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (tx) tx_ones++;
            if (done) done_cnt++;
            if (err) err_cnt++;
        end
        total++;
        if ({err_first, busy_first} !== 2'b10) begin
            bad++;
            $display("FAIL bcd_reject got=%b exp=10", {err_first, busy_first});
        end
        total++;
        if (tx_ones != 0 || done_cnt != 0 || err_cnt != 0) begin
            bad++;
            $display("FAIL bcd_quiet got=tx%0d/done%0d/err%0d exp=0/0/0", tx_ones, done_cnt, err_cnt);
        end
`else
        logic [40:0] seq;
        logic [40:0] exp_seq;
        int          lat;
        logic [19:0] res;
        logic        busy_at;
        exp_seq = {8'hA5, 1'b0, 16'h12A4, 16'h0001};
        run_op(1'b0, 16'h12A4, 16'h0001, seq, lat, res, busy_at);
        total++;
        if (seq !== exp_seq) begin
            bad++;
            $display("FAIL nocheck_frame got=%h exp=%h", seq, exp_seq);
        end
        total++;
        if (lat == 0 || err !== 1'b0) begin
            bad++;
            $display("FAIL nocheck_done got=lat%0d/err%b exp=done/err0", lat, err);
        end
        @(negedge clock);
`endif
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        ref_lat = 0;
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_timeout();
        test_reset_mid_frame();
        test_bcd_check();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
